// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared sizing constants for the Hack memory hierarchy. RAM8, RAM64 and the
// PC all pick up their default word width and address width from here, so a
// width change only has to be made in one place.
//
// Contents:
//   WIDTH  - data word width in bits
//   ADDR_W - address width of a single RAM8 bank
//   DEPTH  - number of words in a RAM8 bank (2**ADDR_W)
// -----------------------------------------------------------------------------
package hack_pkg;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

endpackage : hack_pkg

// File: rtl/ram8_register16.sv
// -----------------------------------------------------------------------------
// register16
// WIDTH-bit register with load enable, built the Hack way: every bit is a
// 2:1 mux (sel=load, a=stored value, b=in) feeding a D flip-flop, so the
// flop recirculates its own value whenever load is low.
//
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset, clears the register to 0
//   in    in   WIDTH-bit data to capture
//   load  in   capture in on the next rising edge when high
//   out   out  WIDTH-bit stored value
// -----------------------------------------------------------------------------
module register16
  import hack_pkg::*;
#(
  parameter int WIDTH = hack_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stored_q;
  logic [WIDTH-1:0] stored_d;

  // Per-bit feedback mux: keep the stored bit unless load selects the new one.
  always_comb begin
    stored_d = stored_q;
    for (int b = 0; b < WIDTH; b++) begin
      stored_d[b] = load ? in[b] : stored_q[b];
    end
  end

  // Bank of D flip-flops; reset clears every bit regardless of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stored_q <= '0;
    end else begin
      stored_q <= stored_d;
    end
  end

  assign out = stored_q;

endmodule : register16

// File: rtl/ram8.sv
// -----------------------------------------------------------------------------
// ram8
// Eight-word RAM made from eight register16 instances. A one-hot write
// decoder routes load to the addressed word only, and an 8-way mux drives
// the addressed word onto out with no clock delay. Reads never bypass the
// write path: during a write cycle out shows the old word until the edge.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset, clears all words to 0
//   in      in   WIDTH-bit write data
//   load    in   write enable for the addressed word
//   address in   ADDR_W-bit word select for both read and write
//   out     out  WIDTH-bit contents of the addressed word
// -----------------------------------------------------------------------------
module ram8
  import hack_pkg::*;
#(
  parameter int WIDTH  = hack_pkg::WIDTH,
  parameter int ADDR_W = hack_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  localparam int Depth = 2 ** ADDR_W;

  logic [Depth-1:0] loadVec;
  logic [WIDTH-1:0] words [Depth];

  // Write decode (DMux8Way): load reaches exactly one word, or none when low.
  always_comb begin
    loadVec = '0;
    if (load) begin
      loadVec[address] = 1'b1;
    end
  end

  for (genvar g = 0; g < Depth; g++) begin : gWord
    register16 #(
      .WIDTH(WIDTH)
    ) uWord (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (in),
      .load (loadVec[g]),
      .out  (words[g])
    );
  end

  // Read select (Mux8Way16): purely combinational, follows address immediately.
  assign out = words[address];

endmodule : ram8

// File: tb/tb_ram8.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_ram8
// Self-checking bench for ram8. A plain array holds the expected memory
// contents; a compare process checks out against it every falling edge,
// and directed sequences pin the array with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_ram8;

  localparam int W  = 16;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic [W-1:0]  in      = '0;
  logic          load    = 1'b0;
  logic [AW-1:0] address = '0;
  logic [W-1:0]  out;

  int checks = 0;
  int passes = 0;
  bit cmpEnable = 1'b0;

  logic [W-1:0] mem [N];

  ram8 #(
    .WIDTH (W),
    .ADDR_W(AW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .load   (load),
    .address(address),
    .out    (out)
  );

  // 10 ns clock: rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Expected memory contents: reset clears everything, otherwise a rising
  // edge with load high stores in at address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] = '0;
    end else if (load) begin
      mem[address] = in;
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] expected,
                             input logic [W-1:0] actual);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s at %0t: got 0x%04h expected 0x%04h",
               name, $time, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge.
  task automatic applyStimulus(input logic ld, input logic [AW-1:0] a,
                               input logic [W-1:0] d);
    @(negedge clk);
    #1;
    load    = ld;
    address = a;
    in      = d;
  endtask

  // Continuous comparison against the array, away from the rising edge.
  always @(negedge clk) begin
    if (cmpEnable) begin
      checkOutput("model", rst_n ? mem[address] : '0, out);
    end
  end

  initial begin
    logic [W-1:0] expVal;

    // Assert reset with a genuine falling edge, then sweep all addresses.
    #2;
    rst_n = 1'b0;
    cmpEnable = 1'b1;
    for (int a = 0; a < N; a++) begin
      address = AW'(a);
      #0.5;
      checkOutput("resetInitial", 16'h0000, out);
    end
    #15;
    rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 60; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)),
                    W'($urandom));
    end
    applyStimulus(1'b0, 3'd0, 16'h0000);

    // Reset pulse in the middle of a high phase, no clock edge during sweep.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int a = 0; a < N; a++) begin
      address = AW'(a);
      #0.4;
      checkOutput("resetPulse", 16'h0000, out);
    end
    #0.3;
    rst_n = 1'b1;

    // Single write to address 3, then readback at every address.
    applyStimulus(1'b1, 3'd3, 16'h1234);
    applyStimulus(1'b0, 3'd3, 16'h0000);
    for (int a = 0; a < N; a++) begin
      address = AW'(a);
      #0.4;
      expVal = (a == 3) ? 16'h1234 : 16'h0000;
      checkOutput("singleWrite", expVal, out);
    end
    checkOutput("modelPin3", 16'h1234, mem[3]);

    // Read during write at address 5: old value before edge, new value after.
    applyStimulus(1'b1, 3'd5, 16'h00AA);
    applyStimulus(1'b1, 3'd5, 16'h5555);
    #1;
    checkOutput("rdwBefore", 16'h00AA, out);
    @(posedge clk);
    #1;
    checkOutput("rdwAfter", 16'h5555, out);

    // Hold: load low with all-ones data for four edges.
    applyStimulus(1'b0, 3'd3, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("hold", 16'h1234, out);
    end

    // Fill and readback, including the 7 -> 0 address wrap.
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b1, AW'(i), W'(16'h1000 + i));
    end
    applyStimulus(1'b0, 3'd0, 16'h0000);
    for (int i = 0; i <= N; i++) begin
      address = AW'(i % N);
      #0.4;
      checkOutput("fill", W'(16'h1000 + (i % N)), out);
    end
    checkOutput("modelPin7", 16'h1007, mem[7]);

    // Reset asserted together with a pending write to word 7.
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    load    = 1'b1;
    in      = 16'hBEEF;
    address = 3'd7;
    @(posedge clk);
    #1;
    checkOutput("pendingDuring", 16'h0000, out);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    load  = 1'b0;
    #1;
    checkOutput("pendingAfter", 16'h0000, out);
    checkOutput("modelPinRst", 16'h0000, mem[7]);

    // First write after release lands on the first loading edge.
    applyStimulus(1'b1, 3'd7, 16'hCAFE);
    #1;
    checkOutput("firstWriteBefore", 16'h0000, out);
    @(posedge clk);
    #1;
    checkOutput("firstWriteAfter", 16'hCAFE, out);

    // More random traffic after the directed section.
    for (int c = 0; c < 60; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)),
                    W'($urandom));
    end
    applyStimulus(1'b0, 3'd0, 16'h0000);
    @(negedge clk);
    #1;
    cmpEnable = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_ram8
